// File: rtl/st_event_logger.sv
// st_event_logger: times shoot-through pulses per channel,
// queues {channel,width} records, streams them as UART 8N1.
module st_event_logger #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH_BITS   = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] det,
  input  logic                clr,
  output logic                tx,
  output logic                overflow,
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 4 + WIDTH_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [WIDTH_BITS-1:0] SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [CHANNELS-1:0]   det_q;
  logic [CHANNELS-1:0]   pend;
  logic [CHANNELS-1:0]   fall;
  logic [CHANNELS-1:0]   drop;
  logic [CHANNELS-1:0]   grant;
  logic [WIDTH_BITS-1:0] cnt [CHANNELS];
  logic [WIDTH_BITS-1:0] rec [CHANNELS];

  logic          wr_en;
  logic          rd_en;
  logic [RW-1:0] wr_data;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          full;
  logic          empty;

  state_t        state;
  logic [1:0]    b;
  logic [2:0]    bit_i;
  logic [CW-1:0] clk_cnt;
  logic [RW-1:0] rec_q;
  logic [7:0]    cur_byte;
  logic          bit_end;

  assign fall  = ~det & det_q;
  // a fall only drops when its pend is not draining this cycle
  assign drop  = fall & pend & ~grant;
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign rd_en = (state == IDLE) && !empty;
  assign busy  = !empty || (state != IDLE);
  assign bit_end = (clk_cnt == BIT_LAST);

  // fixed-priority pick of the lowest pending channel
  always_comb begin
    grant   = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pend[i] && !full && !wr_en) begin
        grant[i] = 1'b1;
        wr_en    = 1'b1;
        wr_data  = {4'(i), rec[i]};
      end
    end
  end

  // per-channel pulse timing and pending record capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q <= '0;
      pend  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        rec[i] <= '0;
      end
    end else begin
      det_q <= det;
      for (int i = 0; i < CHANNELS; i++) begin
        if (det[i] && !det_q[i])
          cnt[i] <= WIDTH_BITS'(1);
        else if (det[i] && cnt[i] != SAT)
          cnt[i] <= cnt[i] + WIDTH_BITS'(1);
        if (fall[i] && !drop[i]) begin
          rec[i]  <= cnt[i];
          pend[i] <= 1'b1;
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // sticky drop flag; a new drop beats clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (|drop)
      overflow <= 1'b1;
    else if (clr)
      overflow <= 1'b0;
  end

  // record storage, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wp[AW-1:0]] <= wr_data;
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en)
        wp <= wp + 1'b1;
      if (rd_en)
        rp <= rp + 1'b1;
    end
  end

  // byte select for the record being sent
  always_comb begin
    unique case (b)
      2'd0:    cur_byte = {4'hA, rec_q[RW-1 -: 4]};
      2'd1:    cur_byte = rec_q[WIDTH_BITS-1 -: 8];
      default: cur_byte = rec_q[7:0];
    endcase
  end

  // UART framer: three 8N1 bytes per record, tx registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      b       <= '0;
      bit_i   <= '0;
      clk_cnt <= '0;
      rec_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          tx      <= 1'b1;
          if (!empty) begin
            rec_q <= mem[rp[AW-1:0]];
            b     <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_i   <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_i == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_i <= bit_i + 3'd1;
              tx    <= cur_byte[3'(bit_i + 3'd1)];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (b != 2'd2) begin
              b     <= b + 2'd1;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
